// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;
    localparam int UART_DATA_W = 8;
    localparam int TIMEOUT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        HOLD
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);
    localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] cand;
    logic           found;

    // One extra bit holds rr_ptr+k before folding it back into 0..NUM_REQ-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NUM_L) begin
                cand = cand - NUM_L;
            end
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found                     = 1'b1;
                grant[cand[IDX_W-1:0]]    = 1'b1;
                grant_idx                 = cand[IDX_W-1:0];
            end
        end
    end

    assign any_valid = |req_valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters, round-robin,
// with optional multi-byte locking released by an idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1023
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           TX_start,
    output logic [UART_DATA_W-1:0]         TX_data,
    input  logic                           TX_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(HOLD_TIMEOUT);

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic                 last_q;
    logic [TIMEOUT_W-1:0] hold_cnt;

    logic [UART_DATA_W-1:0] req_byte [NUM_REQ];
    logic [NUM_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   any_valid;
    logic [NUM_REQ-1:0]     hold_onehot;
    logic [NUM_REQ-1:0]     sel_onehot;
    logic [IDX_W-1:0]       sel_idx;
    logic                   accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign req_byte[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (any_valid)
    );

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] id);
        return (id == IDX_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    assign hold_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

    // While locked only the owner can be accepted; otherwise the arbiter decides.
    always_comb begin
        sel_idx    = arb_idx;
        sel_onehot = arb_grant;
        accept     = 1'b0;
        if (state == HOLD) begin
            sel_idx    = grant_id;
            sel_onehot = hold_onehot;
            accept     = req_valid[grant_id];
        end else if (state == IDLE) begin
            accept     = any_valid;
        end
    end

    assign req_ready = (accept && !reset) ? sel_onehot : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            TX_start <= 1'b0;
            TX_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            TX_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        TX_data  <= req_byte[sel_idx];
                        grant_id <= sel_idx;
                        last_q   <= req_last[sel_idx];
                        TX_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (TX_done) begin
                        if (last_q) begin
                            rr_ptr <= next_ptr(grant_id);
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        TX_data  <= req_byte[sel_idx];
                        last_q   <= req_last[sel_idx];
                        TX_start <= 1'b1;
                        state    <= SEND;
                    end else if (hold_cnt == TIMEOUT_VAL) begin
                        // Owner stalled too long: drop the lock and move past it.
                        rr_ptr <= next_ptr(grant_id);
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, fairness, lock, timeout, reset.
module tb_uart_tx_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        TX_start;
    logic [7:0]  TX_data;
    logic        TX_done;
    logic [1:0]  grant_id;
    logic        busy;

    logic tx_done_man  = 1'b0;
    logic tx_done_auto = 1'b0;
    logic uart_auto    = 1'b0;
    int   uart_delay   = 10;
    assign TX_done = tx_done_man | tx_done_auto;

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .HOLD_TIMEOUT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .TX_start  (TX_start),
        .TX_data   (TX_data),
        .TX_done   (TX_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor and logs
    int   rcnt [4];
    int   glog [$];
    int   txlog [$];
    logic tracking = 1'b0;
    logic [7:0] held = '0;

    always @(negedge clock) begin
        if (reset) begin
            tracking = 1'b0;
        end else begin
            if (req_ready != 4'b0000) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        rcnt[i]++;
                        glog.push_back(i);
                    end
                end
            end
            if (TX_start) begin
                tracking = 1'b1;
                held     = TX_data;
                txlog.push_back(int'(grant_id) * 256 + int'(TX_data));
            end else if (tracking) begin
                chk("tx_data_stable", 32'(TX_data), 32'(held));
            end
            if (TX_done) tracking = 1'b0;
        end
    end

    // UART model: TX_done uart_delay cycles after each TX_start
    initial begin
        forever begin
            @(negedge clock);
            if (uart_auto && TX_start) begin
                repeat (uart_delay) @(posedge clock);
                #2 tx_done_auto = 1'b1;
                @(posedge clock);
                #2 tx_done_auto = 1'b0;
            end
        end
    end

    // Requester model: pending bytes per requester, {last, data}
    logic [8:0] pend [4][4];
    int pn [4];
    int pp [4];
    int seen [4];

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input int i);
        if (pp[i] < pn[i]) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = pend[i][pp[i]][7:0];
            req_last[i]         = pend[i][pp[i]][8];
            pp[i]++;
        end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
        end
    endtask

    task automatic tick_auto();
        tick();
        for (int i = 0; i < 4; i++) begin
            if (rcnt[i] != seen[i]) begin
                seen[i] = rcnt[i];
                load(i);
            end
        end
    endtask

    task automatic start_auto();
        for (int i = 0; i < 4; i++) begin
            seen[i] = rcnt[i];
            pn[i]   = 0;
            pp[i]   = 0;
        end
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((busy || req_valid != 4'b0000) && n < max) begin
            tick_auto();
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        tx_done_man = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int base_tx;
        int base_g;
        int base_r [4];

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", TX_start, 0);
        chk("rst_data", TX_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);

        // Single byte from requester 2
        req_valid = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0100;
        #1;
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_busy_idle", busy, 0);
        tick();
        req_valid = '0; req_last = '0;
        #1;
        chk("t1_start", TX_start, 1);
        chk("t1_data", TX_data, 8'h41);
        chk("t1_grant", grant_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_ready_send", req_ready, 0);
        tick();
        chk("t1_start_pulse", TX_start, 0);
        tick();
        tick();
        tx_done_man = 1'b1;
        tick();
        tx_done_man = 1'b0;
        chk("t1_idle", busy, 0);
        chk("t1_grant_kept", grant_id, 2);
        req_valid = 4'b1100; req_last = 4'b1100;
        #1;
        chk("t1_rrptr", req_ready, 4'b1000);

        // Fairness: all four valid, requester 0 has a second byte
        do_reset();
        start_auto();
        uart_delay = 10;
        uart_auto  = 1'b1;
        pend[0][0] = 9'h1B0; pend[0][1] = 9'h1C0; pn[0] = 2;
        pend[1][0] = 9'h1B1; pn[1] = 1;
        pend[2][0] = 9'h1B2; pn[2] = 1;
        pend[3][0] = 9'h1B3; pn[3] = 1;
        base_tx = txlog.size();
        base_g  = glog.size();
        for (int i = 0; i < 4; i++) base_r[i] = rcnt[i];
        for (int i = 0; i < 4; i++) load(i);
        #1;
        chk("fair_first_ready", req_ready, 4'b0001);
        run_until_idle("fair_drain", 300);
        chk("fair_count", txlog.size() - base_tx, 5);
        if (txlog.size() - base_tx == 5) begin
            chk("fair_tx0", txlog[base_tx + 0], 32'h0B0);
            chk("fair_tx1", txlog[base_tx + 1], 32'h1B1);
            chk("fair_tx2", txlog[base_tx + 2], 32'h2B2);
            chk("fair_tx3", txlog[base_tx + 3], 32'h3B3);
            chk("fair_tx4", txlog[base_tx + 4], 32'h0C0);
        end
        chk("fair_gcount", glog.size() - base_g, 5);
        if (glog.size() - base_g == 5) begin
            chk("fair_g4", glog[base_g + 4], 0);
        end
        chk("fair_r0", rcnt[0] - base_r[0], 2);
        chk("fair_r1", rcnt[1] - base_r[1], 1);
        chk("fair_r2", rcnt[2] - base_r[2], 1);
        chk("fair_r3", rcnt[3] - base_r[3], 1);
        uart_auto = 1'b0;

        // Lock: requester 1 message of three bytes while requester 0 waits
        do_reset();
        start_auto();
        uart_auto  = 1'b1;
        uart_delay = 6;
        pend[1][0] = 9'h010; pend[1][1] = 9'h011; pend[1][2] = 9'h112; pn[1] = 3;
        pend[0][0] = 9'h1A0; pn[0] = 1;
        base_tx = txlog.size();
        load(1);
        #1;
        chk("lock_first_ready", req_ready, 4'b0010);
        tick_auto();
        load(0);
        run_until_idle("lock_drain", 300);
        chk("lock_count", txlog.size() - base_tx, 4);
        if (txlog.size() - base_tx == 4) begin
            chk("lock_tx0", txlog[base_tx + 0], 32'h110);
            chk("lock_tx1", txlog[base_tx + 1], 32'h111);
            chk("lock_tx2", txlog[base_tx + 2], 32'h112);
            chk("lock_tx3", txlog[base_tx + 3], 32'h0A0);
        end
        uart_auto = 1'b0;

        // Timeout: requester 3 opens a lock and stalls, requester 0 waits
        do_reset();
        req_valid = 4'b1000; req_data[31:24] = 8'h33; req_last = 4'b0000;
        #1;
        chk("to_ready3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001; req_data[7:0] = 8'h55; req_last = 4'b0001;
        #1;
        chk("to_start", TX_start, 1);
        chk("to_grant", grant_id, 3);
        chk("to_ready_send", req_ready, 0);
        tick();
        #1;
        chk("to_ready_wait", req_ready, 0);
        tx_done_man = 1'b1;
        tick();
        tx_done_man = 1'b0;
        for (int c = 3; c <= 11; c++) begin
            tx_done_man = (c == 5);
            #1;
            chk("to_hold_ready", req_ready, 0);
            chk("to_hold_busy", busy, 1);
            chk("to_hold_start", TX_start, 0);
            tick();
        end
        tx_done_man = 1'b0;
        #1;
        chk("to_release_busy", busy, 0);
        chk("to_release_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0; req_last = '0;
        #1;
        chk("to_next_start", TX_start, 1);
        chk("to_next_data", TX_data, 8'h55);
        chk("to_next_grant", grant_id, 0);
        tick();
        tx_done_man = 1'b1;
        tick();
        tx_done_man = 1'b0;
        chk("to_end_idle", busy, 0);

        // Reset in WAIT, then a stray TX_done
        do_reset();
        req_valid = 4'b0010; req_data[15:8] = 8'h77; req_last = 4'b0010;
        tick();
        req_valid = '0; req_last = '0;
        #1;
        chk("rm_start", TX_start, 1);
        tick();
        chk("rm_busy_wait", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_start0", TX_start, 0);
        chk("rm_ready", req_ready, 0);
        chk("rm_grant", grant_id, 0);
        chk("rm_data", TX_data, 0);
        tx_done_man = 1'b1;
        tick();
        tx_done_man = 1'b0;
        #1;
        chk("rm_stray_busy", busy, 0);
        chk("rm_stray_start", TX_start, 0);
        chk("rm_stray_grant", grant_id, 0);
        chk("rm_stray_data", TX_data, 0);
        tick();
        chk("rm_stray_busy2", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
